// File: rtl/ad936x_tx_pkg.sv
// Shared definitions for the AD936x LVDS transmit framer: FSM encoding,
// frame lengths per mode and the TX_FRAME pattern helpers.
package ad936x_tx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Nibble slots per frame: one channel in 1R1T, two in 2R2T.
  // Each channel takes an MSB slot followed by an LSB slot.
  localparam int SLOTS_1R1T = 2;
  localparam int SLOTS_2R2T = 4;

  // Wide enough to index every slot of the longest frame.
  localparam int SLOT_W = 2;

  // TX_FRAME is high for the first half of the frame and low for the second.
  function automatic logic frame_bit(input logic [SLOT_W-1:0] slot, input logic two_ch);
    logic bit_v;
    if (two_ch) begin
      bit_v = (slot < SLOT_W'(SLOTS_2R2T / 2));
    end else begin
      bit_v = (slot < SLOT_W'(SLOTS_1R1T / 2));
    end
    return bit_v;
  endfunction

  // Index of the final slot in a frame, where the next frame is decided.
  function automatic logic [SLOT_W-1:0] last_slot(input logic two_ch);
    logic [SLOT_W-1:0] last_v;
    if (two_ch) begin
      last_v = SLOT_W'(SLOTS_2R2T - 1);
    end else begin
      last_v = SLOT_W'(SLOTS_1R1T - 1);
    end
    return last_v;
  endfunction

endpackage

// File: rtl/ad936x_tx_fifo.sv
// Small synchronous sample FIFO. A pushed word becomes visible on data_o
// (and poppable) the cycle after the push; there is no fall-through path.
// A push offered while full is dropped; a pop offered while empty is ignored.
module ad936x_tx_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == (AW + 1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Next pointer and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (!do_push && do_pop) begin
      level_d = level_q - 1'b1;
    end
  end

  // Pointer and level state; reset empties the FIFO without touching storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Sample storage write port.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/ad936x_lvds_tx_framer.sv
// AD936x LVDS transmit framer. Buffers packed I/Q samples, then slices each
// sample into MSB/LSB nibble pairs (I on the rising-edge D1 vector, Q on the
// falling-edge D2 vector) alongside the TX_FRAME pattern. When the FIFO runs
// dry at a frame boundary the frame is still emitted, carrying zeros, so the
// PHY never loses frame alignment. Outputs feed an external ODDR stage.
module ad936x_lvds_tx_framer #(
  parameter int DATA_W     = 12,
  parameter int LANE_W     = 6,
  parameter int MAX_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int UCNT_W     = 16
) (
  input  logic                          fb_clk,
  input  logic                          rst_n,
  input  logic                          tx_en,
  input  logic                          mode_2ch,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [2*DATA_W*MAX_CH-1:0]    s_data,
  output logic [LANE_W-1:0]             tx_d1,
  output logic [LANE_W-1:0]             tx_d2,
  output logic                          tx_frame_d1,
  output logic                          tx_frame_d2,
  output logic                          busy,
  output logic                          underflow,
  output logic [UCNT_W-1:0]             underflow_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  import ad936x_tx_pkg::*;

  localparam int SW    = 2 * DATA_W * MAX_CH;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // Reject parameter sets the slicing logic cannot represent.
  if (!(MAX_CH == 1 || MAX_CH == 2)) begin : g_bad_max_ch
    $error("ad936x_lvds_tx_framer: MAX_CH must be 1 or 2");
  end
  if (DATA_W != 2 * LANE_W) begin : g_bad_data_w
    $error("ad936x_lvds_tx_framer: DATA_W must equal 2*LANE_W");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ad936x_lvds_tx_framer: FIFO_DEPTH must be a power of 2, at least 2");
  end

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                mode_q, mode_d;
  logic [SW-1:0]       sample_q, sample_d;
  logic [LANE_W-1:0]   d1_q, d1_d;
  logic [LANE_W-1:0]   d2_q, d2_d;
  logic                frame_q, frame_d;
  logic                uf_q, uf_d;
  logic [UCNT_W-1:0]   ucnt_q, ucnt_d;

  logic                mode_eff;
  logic                at_last;
  logic                frame_start;
  logic                starve;
  logic                fifo_push;
  logic                fifo_pop;
  logic [SW-1:0]       fifo_dout;
  logic [LVL_W-1:0]    level;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DATA_W-1:0]   i_word;
  logic [DATA_W-1:0]   q_word;

  // Single-channel builds cannot run 2R2T regardless of the pin.
  assign mode_eff  = (MAX_CH == 2) ? mode_2ch : 1'b0;
  assign at_last   = (slot_q == last_slot(mode_q));
  assign s_ready   = !fifo_full;
  assign fifo_push = s_valid && s_ready;
  assign fifo_pop  = frame_start && !fifo_empty;
  assign starve    = frame_start && fifo_empty;

  ad936x_tx_fifo #(
    .WIDTH (SW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (fb_clk),
    .rst_ni  (rst_n),
    .push_i  (fifo_push),
    .data_i  (s_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .level_o (level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Channel selection: in 2R2T slots 0/1 carry channel 0 and slots 2/3 channel 1.
  if (MAX_CH == 2) begin : g_two_ch
    assign i_word = slot_q[1] ? sample_q[2*DATA_W +: DATA_W] : sample_q[0 +: DATA_W];
    assign q_word = slot_q[1] ? sample_q[3*DATA_W +: DATA_W] : sample_q[DATA_W +: DATA_W];
  end else begin : g_one_ch
    assign i_word = sample_q[0 +: DATA_W];
    assign q_word = sample_q[DATA_W +: DATA_W];
  end

  // FSM state register.
  always_ff @(posedge fb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: start once data is queued, stop only at a frame boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (tx_en && !fifo_empty) state_d = ST_RUN;
      ST_RUN:  if (at_last && !tx_en)    state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: a new frame begins on entry to RUN or on a wrap with tx_en held.
  always_comb begin
    frame_start = 1'b0;
    case (state_q)
      ST_IDLE: frame_start = tx_en && !fifo_empty;
      ST_RUN:  frame_start = at_last && tx_en;
      default: frame_start = 1'b0;
    endcase
  end

  // Slot counter, mode shadow, sample holding register and underflow accounting.
  always_comb begin
    slot_d   = slot_q;
    mode_d   = mode_q;
    sample_d = sample_q;
    uf_d     = 1'b0;
    ucnt_d   = ucnt_q;
    if (state_q == ST_IDLE) begin
      mode_d = mode_eff;
      slot_d = '0;
    end else begin
      slot_d = at_last ? '0 : slot_q + 1'b1;
    end
    if (fifo_pop) begin
      sample_d = fifo_dout;
    end else if (starve) begin
      sample_d = '0;
      uf_d     = 1'b1;
      if (ucnt_q != '1) begin
        ucnt_d = ucnt_q + 1'b1;
      end
    end
  end

  // Output stage: slices the held sample by the current slot, one cycle behind it.
  always_comb begin
    d1_d    = '0;
    d2_d    = '0;
    frame_d = 1'b0;
    if (state_q == ST_RUN) begin
      if (!slot_q[0]) begin
        d1_d = i_word[DATA_W-1 -: LANE_W];
        d2_d = q_word[DATA_W-1 -: LANE_W];
      end else begin
        d1_d = i_word[LANE_W-1:0];
        d2_d = q_word[LANE_W-1:0];
      end
      frame_d = frame_bit(slot_q, mode_q);
    end
  end

  // Datapath and output registers; everything clears at once on reset.
  always_ff @(posedge fb_clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= '0;
      mode_q   <= 1'b0;
      sample_q <= '0;
      uf_q     <= 1'b0;
      ucnt_q   <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      frame_q  <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      mode_q   <= mode_d;
      sample_q <= sample_d;
      uf_q     <= uf_d;
      ucnt_q   <= ucnt_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      frame_q  <= frame_d;
    end
  end

  assign tx_d1         = d1_q;
  assign tx_d2         = d2_q;
  assign tx_frame_d1   = frame_q;
  assign tx_frame_d2   = frame_q;
  assign busy          = (state_q == ST_RUN);
  assign underflow     = uf_q;
  assign underflow_cnt = ucnt_q;
  assign fifo_level    = level;

endmodule

// File: tb/tb_ad936x_lvds_tx_framer.sv
// Scoreboard bench for ad936x_lvds_tx_framer (default parameters).
// Stimulus pushes hand-computed slot outputs into sb_q; a negedge monitor
// pops and compares each output word emitted while the framer is running.
module tb_ad936x_lvds_tx_framer;

  logic        fb_clk = 1'b0;
  logic        rst_n;
  logic        tx_en;
  logic        mode_2ch;
  logic        s_valid;
  logic        s_ready;
  logic [47:0] s_data;
  logic [5:0]  tx_d1;
  logic [5:0]  tx_d2;
  logic        tx_frame_d1;
  logic        tx_frame_d2;
  logic        busy;
  logic        underflow;
  logic [15:0] underflow_cnt;
  logic [2:0]  fifo_level;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [13:0] sb_q[$];
  logic [13:0] obs;
  logic [13:0] exp_w;
  logic        prev_busy = 1'b0;
  int          upulses;
  int          k;

  always #5 fb_clk = ~fb_clk;

  ad936x_lvds_tx_framer dut (
    .fb_clk        (fb_clk),
    .rst_n         (rst_n),
    .tx_en         (tx_en),
    .mode_2ch      (mode_2ch),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .tx_d1         (tx_d1),
    .tx_d2         (tx_d2),
    .tx_frame_d1   (tx_frame_d1),
    .tx_frame_d2   (tx_frame_d2),
    .busy          (busy),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt),
    .fifo_level    (fifo_level)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge fb_clk);
    #1;
  endtask

  // {Q1, I1, Q0, I0}
  function automatic logic [47:0] pk(input logic [11:0] i0, input logic [11:0] q0,
                                     input logic [11:0] i1, input logic [11:0] q1);
    return {q1, i1, q0, i0};
  endfunction

  task automatic exp_slot(input logic [5:0] d1, input logic [5:0] d2, input logic f);
    sb_q.push_back({d1, d2, f, f});
  endtask

  // Offer one sample and hold it until the framer accepts it.
  task automatic send(input logic [47:0] d);
    int   n;
    logic r;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    do begin
      @(negedge fb_clk);
      r = s_ready;
      @(posedge fb_clk);
      #1;
      n++;
    end while (!r && n < 20);
    if (!r) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: sample 0x%0h not accepted after %0d cycles", d, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    tx_en    = 1'b0;
    mode_2ch = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;

    fork
      begin : monitor
        forever begin
          @(negedge fb_clk);
          if (!rst_n) begin
            sb_q.delete();
            prev_busy = 1'b0;
          end else begin
            obs = {tx_d1, tx_d2, tx_frame_d1, tx_frame_d2};
            if (prev_busy) begin
              if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_stream: unexpected output 0x%0h, scoreboard empty", obs);
              end else begin
                exp_w = sb_q.pop_front();
                check("tx_stream", obs, exp_w);
              end
            end else begin
              check("idle_outputs_zero", obs, 0);
            end
            prev_busy = busy;
          end
        end
      end
    join_none

    // Reset state
    repeat (3) tick();
    check("rst_s_ready", s_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_underflow_cnt", underflow_cnt, 0);
    check("rst_underflow", underflow, 0);
    check("rst_tx_outputs", {tx_d1, tx_d2, tx_frame_d1, tx_frame_d2}, 0);
    rst_n = 1'b1;
    tick();

    // 1R1T streaming: two samples, stop after the second frame
    send(pk(12'hABC, 12'h123, 12'h000, 12'h000));
    send(pk(12'h456, 12'h789, 12'h000, 12'h000));
    s_valid = 1'b0;
    tx_en   = 1'b1;
    exp_slot(6'h2A, 6'h04, 1'b1); exp_slot(6'h3C, 6'h23, 1'b0);
    exp_slot(6'h11, 6'h1E, 1'b1); exp_slot(6'h16, 6'h09, 1'b0);
    upulses = 0;
    repeat (3) begin tick(); upulses += int'(underflow); end
    tx_en = 1'b0;
    repeat (3) begin tick(); upulses += int'(underflow); end
    check("t1_no_underflow", upulses, 0);
    check("t1_busy_after", busy, 0);

    // 2R2T frame, tx_en dropped at slot 1 and mode toggled mid-frame
    mode_2ch = 1'b1;
    send(pk(12'hFFF, 12'h000, 12'h040, 12'hFC0));
    s_valid = 1'b0;
    tx_en   = 1'b1;
    exp_slot(6'h3F, 6'h00, 1'b1); exp_slot(6'h3F, 6'h00, 1'b1);
    exp_slot(6'h01, 6'h3F, 1'b0); exp_slot(6'h00, 6'h00, 1'b0);
    tick();
    tick();
    tx_en    = 1'b0;
    mode_2ch = 1'b0;
    tick();
    check("t2_busy_slot2", busy, 1);
    tick();
    tick();
    check("t2_busy_after", busy, 0);
    tick();
    check("t2_outputs_zero", {tx_d1, tx_d2, tx_frame_d1, tx_frame_d2}, 0);

    // Underflow: one sample then three starved frames
    send(pk(12'h801, 12'h7FE, 12'h000, 12'h000));
    s_valid = 1'b0;
    tx_en   = 1'b1;
    exp_slot(6'h20, 6'h1F, 1'b1); exp_slot(6'h01, 6'h3E, 1'b0);
    repeat (3) begin exp_slot(6'h00, 6'h00, 1'b1); exp_slot(6'h00, 6'h00, 1'b0); end
    upulses = 0;
    repeat (7) begin tick(); upulses += int'(underflow); end
    tx_en = 1'b0;
    repeat (2) begin tick(); upulses += int'(underflow); end
    check("t3_underflow_pulses", upulses, 3);
    check("t3_underflow_cnt", underflow_cnt, 3);
    check("t3_busy_after", busy, 0);

    // Backpressure: six samples against a depth-4 FIFO in IDLE
    send(pk(12'h041, 12'h082, 12'hFFF, 12'hFFF));
    send(pk(12'h0C3, 12'h104, 12'hFFF, 12'hFFF));
    send(pk(12'h145, 12'h186, 12'hFFF, 12'hFFF));
    send(pk(12'h1C7, 12'h208, 12'hFFF, 12'hFFF));
    s_data = pk(12'h249, 12'h28A, 12'hFFF, 12'hFFF);
    check("t4_full_s_ready", s_ready, 0);
    check("t4_full_level", fifo_level, 4);
    repeat (3) begin
      tick();
      check("t4_held_level", fifo_level, 4);
    end
    tx_en = 1'b1;
    exp_slot(6'h01, 6'h02, 1'b1); exp_slot(6'h01, 6'h02, 1'b0);
    exp_slot(6'h03, 6'h04, 1'b1); exp_slot(6'h03, 6'h04, 1'b0);
    exp_slot(6'h05, 6'h06, 1'b1); exp_slot(6'h05, 6'h06, 1'b0);
    exp_slot(6'h07, 6'h08, 1'b1); exp_slot(6'h07, 6'h08, 1'b0);
    exp_slot(6'h09, 6'h0A, 1'b1); exp_slot(6'h09, 6'h0A, 1'b0);
    exp_slot(6'h3F, 6'h00, 1'b1); exp_slot(6'h00, 6'h3F, 1'b0);
    send(pk(12'h249, 12'h28A, 12'hFFF, 12'hFFF));
    send(pk(12'hFC0, 12'h03F, 12'hFFF, 12'hFFF));
    s_valid = 1'b0;
    k = 0;
    while (fifo_level != 0 && k < 60) begin
      tick();
      k++;
    end
    check("t4_drained_level", fifo_level, 0);
    tick();
    tx_en = 1'b0;
    tick();
    tick();
    check("t4_busy_after", busy, 0);
    check("t4_underflow_cnt_held", underflow_cnt, 3);

    // Reset at slot 1 with three entries still queued
    send(pk(12'h041, 12'h082, 12'h000, 12'h000));
    send(pk(12'h0C3, 12'h104, 12'h000, 12'h000));
    send(pk(12'h145, 12'h186, 12'h000, 12'h000));
    send(pk(12'h1C7, 12'h208, 12'h000, 12'h000));
    s_valid = 1'b0;
    tx_en   = 1'b1;
    exp_slot(6'h01, 6'h02, 1'b1); exp_slot(6'h01, 6'h02, 1'b0);
    tick();
    check("t6_level_queued", fifo_level, 3);
    tick();
    @(negedge fb_clk);
    #1;
    rst_n = 1'b0;
    tx_en = 1'b0;
    #1;
    check("t6_rst_outputs", {tx_d1, tx_d2, tx_frame_d1, tx_frame_d2}, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_level", fifo_level, 0);
    check("t6_rst_underflow_cnt", underflow_cnt, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("t6_post_s_ready", s_ready, 1);
    check("t6_post_level", fifo_level, 0);
    check("t6_post_busy", busy, 0);

    repeat (4) tick();
    check("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
